// File: rtl/sm_rom_arb.sv
// Two-port (fetch/data) arbiter in front of a shared combinational ROM.
// Define SM_ROM_ARB_RR_EN for round-robin; default is D-over-I with I anti-starvation.
module sm_rom_arb #(
  parameter int SIZE     = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic [31:0] mem_a,
  input  logic [31:0] mem_rd
);

  logic        oor;
  logic [31:0] rd_q;

`ifdef SM_ROM_ARB_RR_EN
  // prio_i set means port I was not the most recent winner
  logic prio_i;

  assign i_gnt = i_req & (~d_req | prio_i);
  assign d_gnt = d_req & ~i_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_i <= 1'b1;
    end else if (i_gnt) begin
      prio_i <= 1'b0;
    end else if (d_gnt) begin
      prio_i <= 1'b1;
    end
  end
`else
  logic [7:0] wcnt;
  logic       starve;

  assign starve = (wcnt == 8'(MAX_WAIT));
  assign i_gnt  = i_req & (~d_req | starve);
  assign d_gnt  = d_req & ~i_gnt;

  // a denied I request always coincides with a D grant
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= 8'd0;
    end else if (i_gnt || !i_req) begin
      wcnt <= 8'd0;
    end else if (d_gnt) begin
      wcnt <= wcnt + 8'd1;
    end
  end
`endif

  assign mem_a = d_gnt ? d_addr : i_addr;
  assign oor   = (mem_a >= 32'(SIZE));
  assign rd_q  = oor ? 32'd0 : mem_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      err      <= 1'b0;
      i_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      err      <= (i_gnt | d_gnt) & oor;
      if (i_gnt) begin
        i_rdata <= rd_q;
      end
      if (d_gnt) begin
        d_rdata <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_sm_rom_arb.sv
// Directed scoreboard bench for sm_rom_arb.
// Contention expectations follow SM_ROM_ARB_RR_EN when defined.
module tb_sm_rom_arb;

  localparam int SIZE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, err;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        iv;
    logic        dv;
    logic [31:0] id;
    logic [31:0] dd;
    logic        er;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] last_i = 32'd0;
  logic [31:0] last_d = 32'd0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd5) return 32'h00500093;
    return (a * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  assign mem_rd = rom(mem_a);

  sm_rom_arb #(.SIZE(SIZE), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .err(err), .mem_a(mem_a), .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [31:0] da,
                      input logic eig, input logic edg);
    rsp_t e, o;
    @(negedge clk);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
    #1;
    chk("i_gnt", 32'(i_gnt), 32'(eig));
    chk("d_gnt", 32'(d_gnt), 32'(edg));
    chk("mem_a", mem_a, edg ? da : ia);
    if (r) begin
      last_i = 32'd0;
      last_d = 32'd0;
      e = '{iv: 1'b0, dv: 1'b0, id: 32'd0, dd: 32'd0, er: 1'b0};
    end else begin
      if (eig) last_i = (ia < 32'(SIZE)) ? rom(ia) : 32'd0;
      if (edg) last_d = (da < 32'(SIZE)) ? rom(da) : 32'd0;
      e.iv = eig;
      e.dv = edg;
      e.id = last_i;
      e.dd = last_d;
      e.er = (eig && ia >= 32'(SIZE)) || (edg && da >= 32'(SIZE));
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      o = q.pop_front();
      chk("i_rvalid", 32'(i_rvalid), 32'(o.iv));
      chk("d_rvalid", 32'(d_rvalid), 32'(o.dv));
      chk("i_rdata", i_rdata, o.id);
      chk("d_rdata", d_rdata, o.dd);
      chk("err", 32'(err), 32'(o.er));
    end
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0;
    // reset with a live D grant: no response may follow
    step(1, 0, 0, 1, 3, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 0, 0, 0);
    // single fetch, known opcode
    step(0, 1, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // out-of-range data access, then err clears
    step(0, 0, 0, 1, 64, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    // last legal word
    step(0, 0, 0, 1, 63, 0, 1);
    // back-to-back fetches
    for (int k = 0; k < 4; k++) step(0, 1, 32'(k), 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // out-of-range fetch
    step(0, 1, 200, 0, 0, 1, 0);
    // reset with D grant, then contention from a clean state
    step(1, 0, 0, 1, 3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef SM_ROM_ARB_RR_EN
    pat = 10'b01_0101_0101;
`else
    pat = 10'b10_0001_0000;
`endif
    for (int k = 0; k < 10; k++)
      step(0, 1, 10, 1, 20, pat[k], !pat[k]);
    step(0, 0, 9, 0, 21, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_rom_arb.md
SM_ROM_ARB -- requirements
Module: sm_rom_arb

Interface
REQ-001 Parameter SIZE, default 64, memory depth in 32-bit words; legal word indices are 0..SIZE-1.
REQ-002 Parameter MAX_WAIT, default 4, maximum consecutive denied cycles for port I in fixed-priority mode, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-fetch port read request.
REQ-006 i_addr  input  32  fetch word index.
REQ-007 i_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-008 i_rvalid  output  1  fetch read data valid, one-cycle pulse.
REQ-009 i_rdata  output  32  fetch read data.
REQ-010 d_req  input  1  data-side read request (load from code space).
REQ-011 d_addr  input  32  data word index.
REQ-012 d_gnt  output  1  data request accepted this cycle (combinational).
REQ-013 d_rvalid  output  1  data read data valid, one-cycle pulse.
REQ-014 d_rdata  output  32  data read data.
REQ-015 err  output  1  registered; set with the rvalid of an out-of-range access.
REQ-016 mem_a  output  32  word index to the shared combinational ROM.
REQ-017 mem_rd  input  32  ROM read data, combinational from mem_a.

Function
REQ-018 At most one of i_gnt, d_gnt SHALL be high in any cycle; a gnt SHALL only be high when its req is high.
REQ-019 With exactly one req high, that port SHALL be granted the same cycle.
REQ-020 mem_a SHALL equal the granted port's address; with no grant, mem_a SHALL equal i_addr.
REQ-021 On the edge ending a granted cycle, mem_rd SHALL be captured into the granted port's rdata and its rvalid SHALL be 1 for exactly the next cycle; latency is 1 cycle.
REQ-022 rdata of a port SHALL hold its last value until that port's next response; the non-granted port's rdata and rvalid SHALL be unaffected.
REQ-023 A port may request every cycle; back-to-back grants to one port SHALL yield back-to-back rvalid pulses.
REQ-024 A granted address >= SIZE SHALL return rdata 0 and err 1 with that rvalid; err SHALL be 0 in every other cycle.
REQ-025 Requests are not queued: a denied port SHALL keep req and addr stable until granted; dropping req unwinds nothing.
REQ-026 Arbitration state SHALL advance only on cycles with a grant.

Reset
REQ-027 While rst is high at a rising edge: i_rvalid, d_rvalid, err SHALL be 0; i_rdata, d_rdata SHALL be 0; round-robin pointer SHALL favour port I; wait counter SHALL be 0.
REQ-028 A grant in the cycle rst is asserted SHALL produce no response; the first response after rst deasserts SHALL follow a post-reset grant.
REQ-029 gnt outputs remain combinational during reset; the arbiter SHALL still drive mem_a per REQ-020.

Configuration
REQ-030 Macro SM_ROM_ARB_RR_EN defined: round-robin; on contention grant the port not granted most recently (I after reset); MAX_WAIT unused.
REQ-031 SM_ROM_ARB_RR_EN undefined: fixed priority D over I; an 8-bit counter counts consecutive cycles with i_req high and i_gnt low, resets to 0 on i_gnt or i_req low; when counter equals MAX_WAIT, port I SHALL be granted on contention.
REQ-032 Interface, latency and reset behaviour SHALL be identical in both builds.

Verification
REQ-033 Only i_req=1, i_addr=5, ROM[5]=0x00500093 -> i_gnt=1 same cycle, next cycle i_rvalid=1, i_rdata=0x00500093, d_rvalid=0, err=0.
REQ-034 RR build, both req held 6 cycles -> grants I,D,I,D,I,D; each rvalid one cycle after its grant with correct data.
REQ-035 Fixed build, MAX_WAIT=4, both req held 10 cycles -> D,D,D,D,I,D,D,D,D,I; counter back to 0 after each I grant.
REQ-036 SIZE=64, only d_req=1, d_addr=64 -> next cycle d_rvalid=1, d_rdata=0, err=1; following cycle err=0.
REQ-037 rst high during a grant cycle with d_addr=3 -> next cycle d_rvalid=0, d_rdata=0; after rst low, RR build grants I first on contention.
REQ-038 i_req every cycle, addrs 0,1,2,3 -> i_rvalid high 4 consecutive cycles, i_rdata=ROM[0..3] in order, d_rdata unchanged.
